// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_queue_pkg;

   localparam int unsigned FETCH_NUM_DEF = 2;
   localparam int unsigned DEPTH_DEF     = 16;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Push/pop/flush bundle between IF, the fetch queue and issue.
interface fetch_queue_if
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH     = DEPTH_DEF,
   parameter int unsigned FETCH_NUM = FETCH_NUM_DEF
) ();

   logic                                flush;
   logic                                keep_head;
   fetch_entry_t [FETCH_NUM-1:0]        push_entry;
   logic                                push_ready;
   logic         [1:0]                  pop_num;
   fetch_entry_t [FETCH_NUM-1:0]        fetch_entry;
   logic         [$clog2(DEPTH):0]      count;

   modport master (
      output flush, keep_head, push_entry, pop_num,
      input  push_ready, fetch_entry, count
   );

   modport slave (
      input  flush, keep_head, push_entry, pop_num,
      output push_ready, fetch_entry, count
   );

endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue: up to FETCH_NUM pushes per cycle, exposes the FETCH_NUM oldest entries.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH     = DEPTH_DEF,
   parameter int unsigned FETCH_NUM = FETCH_NUM_DEF
) (
   input logic          clk,
   input logic          rst,
   fetch_queue_if.slave q
);

   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned PushW = $clog2(FETCH_NUM + 1);

   logic [PtrW-1:0]  head_q, head_d;
   logic [PtrW-1:0]  tail_q, tail_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [CntW-1:0]  pop_eff;
   logic [PushW-1:0] push_num;
   logic             push_ready;
   logic             do_push;

   fetch_entry_t mem_q [DEPTH];

   always_comb begin
      push_num = '0;
      for (int unsigned i = 0; i < FETCH_NUM; i++) begin
         if (q.push_entry[i].valid) push_num = push_num + PushW'(1);
      end
   end

   assign push_ready = (count_q <= CntW'(DEPTH - FETCH_NUM));
   assign pop_eff    = (CntW'(q.pop_num) > count_q) ? count_q : CntW'(q.pop_num);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      do_push = 1'b0;
      if (q.flush) begin
         // Keeping the head leaves a one-entry queue starting at the current head.
         if (q.keep_head && (count_q != '0)) begin
            tail_d  = head_q + PtrW'(1);
            count_d = CntW'(1);
         end else begin
            tail_d  = head_q;
            count_d = '0;
         end
      end else begin
         do_push = push_ready;
         head_d  = head_q + PtrW'(pop_eff);
         if (push_ready) tail_d = tail_q + PtrW'(push_num);
         count_d = count_q + (push_ready ? CntW'(push_num) : '0) - pop_eff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; slots beyond count are masked on the read side.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < FETCH_NUM; i++) begin
         if (!rst && do_push && (PushW'(i) < push_num)) begin
            mem_q[tail_q + PtrW'(i)] <= q.push_entry[i];
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < FETCH_NUM; i++) begin
         q.fetch_entry[i] = (count_q > CntW'(i)) ? mem_q[head_q + PtrW'(i)] : '0;
      end
   end

   assign q.push_ready = push_ready;
   assign q.count      = count_q;

   pop_within_count: assert property (@(posedge clk) disable iff (rst)
      CntW'(q.pop_num) <= count_q)
      else $warning("fetch_queue: pop_num %0d exceeds count %0d, pop clamped",
                    q.pop_num, count_q);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned FN    = 2;

   typedef fetch_entry_t [FN-1:0] lanes_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   fetch_entry_t model_q[$];

   fetch_queue_if #(.DEPTH(DEPTH), .FETCH_NUM(FN)) fq_if ();

   fetch_queue #(.DEPTH(DEPTH), .FETCH_NUM(FN)) dut (
      .clk (clk),
      .rst (rst),
      .q   (fq_if.slave)
   );

   always #5 clk = ~clk;

   function automatic fetch_entry_t rand_entry();
      fetch_entry_t e;
      e.valid = 1'b1;
      e.pc    = $urandom;
      e.instr = $urandom;
      return e;
   endfunction

   function automatic lanes_t make_push(input int n);
      lanes_t l;
      l = '0;
      for (int i = 0; i < n; i++) l[i] = rand_entry();
      return l;
   endfunction

   // Drive one cycle of inputs, advance the reference model, sample #1 after the edge.
   task automatic step(input lanes_t pe, input int pop, input logic fl, input logic kh,
                       input logic r);
      int           n;
      int           pe_cnt;
      bit           ready;
      fetch_entry_t h;
      fq_if.push_entry = pe;
      fq_if.pop_num    = 2'(pop);
      fq_if.flush      = fl;
      fq_if.keep_head  = kh;
      rst              = r;
      n = 0;
      for (int i = 0; i < FN; i++) if (pe[i].valid) n++;
      if (r) begin
         model_q.delete();
      end else if (fl) begin
         if (kh && model_q.size() > 0) begin
            h = model_q[0];
            model_q.delete();
            model_q.push_back(h);
         end else begin
            model_q.delete();
         end
      end else begin
         ready  = (model_q.size() <= int'(DEPTH - FN));
         pe_cnt = (pop < model_q.size()) ? pop : model_q.size();
         repeat (pe_cnt) void'(model_q.pop_front());
         if (ready) for (int i = 0; i < n; i++) model_q.push_back(pe[i]);
      end
      @(posedge clk);
      #1;
      fq_if.push_entry = '0;
      fq_if.pop_num    = 2'd0;
      fq_if.flush      = 1'b0;
      fq_if.keep_head  = 1'b0;
      rst              = 1'b0;
   endtask

   task automatic test_reset();
      step('0, 0, 1'b0, 1'b0, 1'b1);
      step('0, 0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (fq_if.count !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_count: got %0d expected 0", fq_if.count);
      end
      tests_run++;
      if (fq_if.push_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b expected 1", fq_if.push_ready);
      end
      for (int i = 0; i < FN; i++) begin
         tests_run++;
         if (fq_if.fetch_entry[i] !== '0) begin
            tests_failed++;
            $display("FAIL reset_entry%0d: got %h expected 0", i, fq_if.fetch_entry[i]);
         end
      end
   endtask

   task automatic test_push_basic();
      fetch_entry_t a, b;
      lanes_t       l;
      a = rand_entry();
      b = rand_entry();
      l[0] = a;
      l[1] = b;
      step(l, 0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.fetch_entry[0] !== a || fq_if.fetch_entry[1] !== b) begin
         tests_failed++;
         $display("FAIL push_basic_entries: got %h %h expected %h %h",
                  fq_if.fetch_entry[0], fq_if.fetch_entry[1], a, b);
      end
      tests_run++;
      if (fq_if.count !== 5'd2) begin
         tests_failed++;
         $display("FAIL push_basic_count: got %0d expected 2", fq_if.count);
      end
   endtask

   task automatic test_full();
      step('0, 0, 1'b1, 1'b0, 1'b0);
      repeat (7) step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      step(make_push(1), 0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd15 || fq_if.push_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_at_15: got count %0d ready %b expected 15 0",
                  fq_if.count, fq_if.push_ready);
      end
      step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd15) begin
         tests_failed++;
         $display("FAIL full_push_ignored: got %0d expected 15", fq_if.count);
      end
      for (int i = 0; i < FN; i++) begin
         tests_run++;
         if (fq_if.fetch_entry[i] !== model_q[i]) begin
            tests_failed++;
            $display("FAIL full_entry%0d: got %h expected %h", i, fq_if.fetch_entry[i],
                     model_q[i]);
         end
      end
      step('0, 1, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd14 || fq_if.push_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL full_pop1: got count %0d ready %b expected 14 1",
                  fq_if.count, fq_if.push_ready);
      end
   endtask

   task automatic test_wrap();
      fetch_entry_t exp;
      step(make_push(2), 2, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd14) begin
         tests_failed++;
         $display("FAIL wrap_push_pop_at_14: got %0d expected 14", fq_if.count);
      end
      for (int c = 0; c < 24; c++) begin
         step(make_push(2), 2, 1'b0, 1'b0, 1'b0);
         tests_run++;
         if (int'(fq_if.count) !== model_q.size()) begin
            tests_failed++;
            $display("FAIL wrap_count c%0d: got %0d expected %0d", c, fq_if.count,
                     model_q.size());
         end
         for (int i = 0; i < FN; i++) begin
            exp = (i < model_q.size()) ? model_q[i] : '0;
            tests_run++;
            if (fq_if.fetch_entry[i] !== exp) begin
               tests_failed++;
               $display("FAIL wrap_entry%0d c%0d: got %h expected %h", i, c,
                        fq_if.fetch_entry[i], exp);
            end
         end
      end
   endtask

   task automatic test_flush_keep();
      fetch_entry_t x;
      step('0, 0, 1'b1, 1'b0, 1'b0);
      step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      step(make_push(1), 0, 1'b0, 1'b0, 1'b0);
      x = model_q[0];
      step(make_push(2), 1, 1'b1, 1'b1, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd1 || fq_if.fetch_entry[0] !== x) begin
         tests_failed++;
         $display("FAIL flush_keep_head: got count %0d head %h expected 1 %h",
                  fq_if.count, fq_if.fetch_entry[0], x);
      end
      tests_run++;
      if (fq_if.fetch_entry[1] !== '0) begin
         tests_failed++;
         $display("FAIL flush_keep_entry1: got %h expected 0", fq_if.fetch_entry[1]);
      end
      step('0, 1, 1'b0, 1'b0, 1'b0);
      step(make_push(2), 0, 1'b1, 1'b1, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd0 || fq_if.fetch_entry[0] !== '0) begin
         tests_failed++;
         $display("FAIL flush_keep_empty: got count %0d head %h expected 0 0",
                  fq_if.count, fq_if.fetch_entry[0]);
      end
   endtask

   task automatic test_flush_plain();
      step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      step(make_push(1), 0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd7) begin
         tests_failed++;
         $display("FAIL flush_plain_setup: got %0d expected 7", fq_if.count);
      end
      step(make_push(2), 2, 1'b1, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd0 || fq_if.fetch_entry !== '0) begin
         tests_failed++;
         $display("FAIL flush_plain: got count %0d entries %h expected 0 0",
                  fq_if.count, fq_if.fetch_entry);
      end
      step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      step(make_push(2), 1, 1'b1, 1'b1, 1'b1);
      tests_run++;
      if (fq_if.count !== 5'd0 || fq_if.fetch_entry !== '0) begin
         tests_failed++;
         $display("FAIL rst_over_flush: got count %0d entries %h expected 0 0",
                  fq_if.count, fq_if.fetch_entry);
      end
   endtask

   task automatic test_underflow();
      step(make_push(1), 0, 1'b0, 1'b0, 1'b0);
      step('0, 2, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd0 || fq_if.fetch_entry !== '0) begin
         tests_failed++;
         $display("FAIL underflow_clamp: got count %0d entries %h expected 0 0",
                  fq_if.count, fq_if.fetch_entry);
      end
      step(make_push(2), 0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fq_if.count !== 5'd2 || fq_if.fetch_entry[0] !== model_q[0]) begin
         tests_failed++;
         $display("FAIL underflow_recover: got count %0d head %h expected 2 %h",
                  fq_if.count, fq_if.fetch_entry[0], model_q[0]);
      end
   endtask

   task automatic test_random();
      fetch_entry_t exp;
      int           n, pop, lim;
      logic         fl, kh;
      for (int c = 0; c < 400; c++) begin
         n   = $urandom_range(2, 0);
         lim = (model_q.size() < 2) ? model_q.size() : 2;
         pop = $urandom_range(lim, 0);
         fl  = ($urandom_range(31, 0) == 0);
         kh  = $urandom_range(1, 0);
         step(make_push(n), pop, fl, kh, 1'b0);
         tests_run++;
         if (int'(fq_if.count) !== model_q.size() ||
             fq_if.push_ready !== (model_q.size() <= int'(DEPTH - FN))) begin
            tests_failed++;
            $display("FAIL random_count c%0d: got %0d/%b expected %0d", c, fq_if.count,
                     fq_if.push_ready, model_q.size());
         end
         for (int i = 0; i < FN; i++) begin
            exp = (i < model_q.size()) ? model_q[i] : '0;
            tests_run++;
            if (fq_if.fetch_entry[i] !== exp) begin
               tests_failed++;
               $display("FAIL random_entry%0d c%0d: got %h expected %h", i, c,
                        fq_if.fetch_entry[i], exp);
            end
         end
      end
   endtask

   initial begin
      fq_if.push_entry = '0;
      fq_if.pop_num    = 2'd0;
      fq_if.flush      = 1'b0;
      fq_if.keep_head  = 1'b0;
      test_reset();
      test_push_basic();
      test_full();
      test_wrap();
      test_flush_keep();
      test_flush_plain();
      test_underflow();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue capacity in fetch entries; power of two, at least 2*FETCH_NUM.
REQ-002 SHALL have parameter FETCH_NUM, default `FETCH_NUM, maximum entries pushed per cycle and number of head entries exposed.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard queue contents (driven by flush_id).
REQ-006 SHALL have port keep_head  input  1  with flush, retain the current head entry (pending delay slot).
REQ-007 SHALL have port push_entry  input  FETCH_NUM x fetch_entry_t  entries from IF, compacted: valid entries occupy the low indices.
REQ-008 SHALL have port push_ready  output  1  queue can accept FETCH_NUM entries this cycle.
REQ-009 SHALL have port pop_num  input  2  entries consumed by issue this cycle (0..2), already gated by stall_id.
REQ-010 SHALL have port fetch_entry  output  FETCH_NUM x fetch_entry_t  oldest entries; entry i valid iff count > i.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-012 push_num SHALL be the number of push_entry[i].valid bits; entries SHALL be written in index order at the tail.
REQ-013 push_ready SHALL be combinational from registered count: 1 iff count <= DEPTH-FETCH_NUM.
REQ-014 Push with push_ready=0 SHALL be ignored entirely; no partial push.
REQ-015 Effective pop SHALL be min(pop_num, count); pop_num > count SHALL be flagged by a simulation assertion.
REQ-016 count_next SHALL be count + push_num - pop_eff, computed at full width with no overflow by construction.
REQ-017 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; all slot indexing SHALL wrap.
REQ-018 An entry pushed in cycle N SHALL first appear on fetch_entry in cycle N+1; there is no fall-through.
REQ-019 fetch_entry SHALL be driven from registered storage and pointers only, with no combinational path from push inputs.
REQ-020 fetch_entry[i] with count <= i SHALL be driven all-zero, including the valid bit.
REQ-021 Simultaneous push and pop in the same cycle, including when full, SHALL both take effect, subject to the REQ-013 readiness.
REQ-022 If flush=1 and keep_head=0, the next count SHALL be 0, and push and pop SHALL be ignored that cycle.
REQ-023 If flush=1, keep_head=1 and count>=1, the next count SHALL be 1 with the head entry unchanged at head; push and pop SHALL be ignored.
REQ-024 If flush=1, keep_head=1 and count=0, the result SHALL be identical to a plain flush.
REQ-025 rst SHALL have priority over flush, and flush over push/pop.

Reset
REQ-026 On rst, head, tail and count SHALL become 0, push_ready SHALL be 1, and all fetch_entry SHALL be zero from the next cycle.
REQ-027 Storage contents SHALL NOT require reset; invalid slots SHALL never be observable.
REQ-028 rst asserted mid-operation SHALL discard all entries, regardless of push, pop or flush that cycle.

Structure
REQ-029 fetch_entry_t, FETCH_NUM and the DEPTH default SHALL live in the shared cpu_defs package.
REQ-030 The block SHALL be a single module with no sub-module; the popcount of push valids SHALL be an internal loop.
REQ-031 Storage SHALL be a register array of DEPTH entries, with one write port per push lane and FETCH_NUM read ports.

Verification
REQ-032 After reset, push 2 entries (A,B) -> next cycle fetch_entry[0]=A and fetch_entry[1]=B, both valid, count=2.
REQ-033 Fill to count=15 (DEPTH=16, FETCH_NUM=2) -> push_ready=0; a push of 2 is ignored and count stays 15; pop 1 -> count=14 and push_ready=1.
REQ-034 With count=14, push 2 and pop 2 in the same cycle -> count=14; entries are correct across the pointer wrap after 20+ cycles.
REQ-035 Flush with keep_head=1 at count=5, head=X, plus a push and a pop that cycle -> count=1, fetch_entry[0]=X, fetch_entry[1] invalid.
REQ-036 Flush with keep_head=0 at count=7 -> count=0 and all fetch_entry invalid next cycle; rst plus flush plus push -> count=0.
REQ-037 pop_num=2 with count=1 -> assertion fires, count=0 and no underflow.
